demux_1x2_8bits_fifo: RTL and testbench
=======================================

// Module: demux_1x2_8bits_fifo
// PURPOSE
//  Byte un-striper: receive side of the 2-lane PCIe byte-striping path. One 8-bit stream with
//  valid is split alternately onto lane 0 and lane 1. Each lane buffers bytes in its own FIFO.
//  The lane phase toggles every clock, so this block is the exact inverse of the 2:1
//  byte-striping mux.
//  Downstream lane logic drains each FIFO independently with a pop strobe.
// PARAMETERS
//  DATA_WIDTH  8  byte width per lane
//  FIFO_DEPTH  4  entries per lane FIFO; power of 2, >= 2
//  ADDR_WIDTH  2  log2(FIFO_DEPTH)
// PORTS
//  clk             in   1             single clock; all logic on posedge
//  reset_L         in   1             synchronous active-low reset
//  data_in         in   DATA_WIDTH    striped byte stream
//  valid_in        in   1             data_in qualifier
//  pop0, pop1      in   1             read strobe for lane 0 / lane 1 FIFO
//  data_out0/1     out  DATA_WIDTH    registered read data for lane 0 / lane 1
//  valid_out0/1    out  1             data_out0/1 holds a popped byte this cycle
//  empty0/1        out  1             lane FIFO empty
//  full0/1         out  1             lane FIFO full
//  count0/1        out  ADDR_WIDTH+1  lane FIFO occupancy, 0..FIFO_DEPTH
//  err_overflow0/1 out  1             sticky: a push was dropped because the FIFO was full
// BEHAVIOUR
//  Reset (reset_L==0 at posedge): selector=0; both FIFO pointers and counts = 0.
//   data_out*=0, valid_out*=0, err_overflow*=0, empty*=1, full*=0.
//   Takes priority over all other inputs; a mid-operation reset discards all buffered data.
//  Lane phase: 1-bit selector toggles on every posedge out of reset, regardless of valid_in.
//   selector==0 steers to lane 0; selector==1 steers to lane 1.
//   The first cycle after reset release is lane 0.
//  Push: valid_in==1 pushes data_in into the FIFO chosen by selector at that posedge.
//   valid_in==0 pushes nothing, but the phase still advances.
//   Only the selected lane is written; the other lane is untouched.
//  Pop: popN==1 and FIFO N not empty -> at that posedge, head byte goes to data_outN,
//   valid_outN=1 and the read pointer advances. Latency is 1 clock from pop to data.
//   Otherwise valid_outN=0 and data_outN holds its last value.
//   Pop on empty is ignored (no pointer move, no error).
//  Occupancy: countN += push - pop. Pushes and pops use effective (accepted) events only.
//   emptyN = (countN==0); fullN = (countN==FIFO_DEPTH). Both are registered with count.
//  Boundaries:
//   push while full, no pop  -> byte dropped, err_overflowN=1 (sticky until reset); count unchanged
//   push+pop same cycle, full  -> both accepted; count stays FIFO_DEPTH; no error
//   push+pop same cycle, empty -> pop ignored, push accepted; count becomes 1
//   pointers wrap modulo FIFO_DEPTH; ordering is strict FIFO per lane
//  Throughput: in each lane, one push every other cycle at most; one pop per cycle at most.
//  Push-to-pop: a byte pushed at edge k is visible (emptyN=0) after edge k.
//   The earliest pop is at edge k+1; data is on data_outN after edge k+1.
// TESTING
//  T1 reset: hold reset_L=0 for 2 clk with random inputs -> all outputs at reset values;
//     empty0=empty1=1, count0=count1=0
//  T2 striping: after reset, valid_in=1 for 8 clk with data_in 0xA0..0xA7
//     -> count0=count1=4, full0=full1=1
//     -> popping each lane gives lane0 A0,A2,A4,A6 and lane1 A1,A3,A5,A7
//     -> valid_out one clk after each pop
//  T3 gaps: valid_in=1 only on odd-phase cycles, data 0x11,0x22,0x33
//     -> lane1 holds 11,22,33 and lane0 stays empty
//     -> pop0 on empty gives valid_out0=0
//  T4 overflow: push 5 bytes 0x01..0x05 into lane0 (even phases), no pops
//     -> full0=1 after 4th push; 5th dropped; err_overflow0=1, err_overflow1=0
//     -> pops return 01,02,03,04
//  T5 full push+pop: lane0 full (B0..B3); pop0=1 in the same cycle as a lane0 push of B4
//     -> data_out0=B0, count0 stays 4, no error
//     -> later pops give B1,B2,B3,B4
//  T6 mid-op reset: lanes partly filled (count0=2, count1=3); reset_L=0 for 1 clk
//     -> counts 0, empties 1, sticky errors cleared, selector restarts at lane 0

Source files
------------

// File: rtl/demux_1x2_8bits_fifo.sv
// Receive-side byte un-striper: alternates an incoming byte stream onto two lanes,
// each buffered in its own FIFO and drained independently by a pop strobe.
module demux_1x2_8bits_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    input  logic                  pop0,
    input  logic                  pop1,
    output logic [DATA_WIDTH-1:0] data_out0,
    output logic [DATA_WIDTH-1:0] data_out1,
    output logic                  valid_out0,
    output logic                  valid_out1,
    output logic                  empty0,
    output logic                  empty1,
    output logic                  full0,
    output logic                  full1,
    output logic [ADDR_WIDTH:0]   count0,
    output logic [ADDR_WIDTH:0]   count1,
    output logic                  err_overflow0,
    output logic                  err_overflow1
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(FIFO_DEPTH);

    // Handshake: valid_in qualifies data_in and is never back-pressured (a push into a
    // full lane is dropped and flagged); popN is accepted only when lane N is non-empty,
    // and valid_outN marks the cycle after an accepted pop.
    logic       selector;
    logic [1:0] pop_v;

    assign pop_v = {pop1, pop0};

    always_ff @(posedge clk) begin
        if (!reset_L) selector <= 1'b0;
        else          selector <= ~selector;
    end

    for (genvar n = 0; n < 2; n++) begin : g_lane
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
        logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
        logic [ADDR_WIDTH:0]   count;
        logic [DATA_WIDTH-1:0] dout;
        logic                  vout;
        logic                  err;
        logic                  push_req, pop_ok, push_ok, push_drop;

        assign push_req = valid_in && (selector == 1'(n));
        assign pop_ok   = pop_v[n] && (count != '0);
        // A full lane still accepts a push when a pop frees the head slot in the same cycle.
        assign push_ok   = push_req && ((count != FULL_COUNT) || pop_ok);
        assign push_drop = push_req && !push_ok;

        always_ff @(posedge clk) begin
            if (reset_L && push_ok) mem[wr_ptr] <= data_in;
        end

        always_ff @(posedge clk) begin
            if (!reset_L) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                dout   <= '0;
                vout   <= 1'b0;
                err    <= 1'b0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                if (pop_ok) begin
                    dout   <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                end
                vout <= pop_ok;
                if (push_drop) err <= 1'b1;
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
                    2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    assign data_out0     = g_lane[0].dout;
    assign data_out1     = g_lane[1].dout;
    assign valid_out0    = g_lane[0].vout;
    assign valid_out1    = g_lane[1].vout;
    assign count0        = g_lane[0].count;
    assign count1        = g_lane[1].count;
    assign empty0        = (g_lane[0].count == '0);
    assign empty1        = (g_lane[1].count == '0);
    assign full0         = (g_lane[0].count == FULL_COUNT);
    assign full1         = (g_lane[1].count == FULL_COUNT);
    assign err_overflow0 = g_lane[0].err;
    assign err_overflow1 = g_lane[1].err;

endmodule

// File: tb/tb_demux_1x2_8bits_fifo.sv
// Bench for the byte un-striper: directed scenarios plus random traffic, every cycle
// compared against a queue-based lane model.
module tb_demux_1x2_8bits_fifo;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in, pop0, pop1;
    logic [7:0] data_out0, data_out1;
    logic       valid_out0, valid_out1, empty0, empty1, full0, full1;
    logic [2:0] count0, count1;
    logic       err_overflow0, err_overflow1;

    int checks = 0;
    int errors = 0;

    // model state
    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];
    bit         phase;
    logic [7:0] exp_dout[2];
    bit         exp_vout[2];
    bit         exp_err[2];

    demux_1x2_8bits_fifo dut (
        .clk(clk), .reset_L(reset_L), .data_in(data_in), .valid_in(valid_in),
        .pop0(pop0), .pop1(pop1), .data_out0(data_out0), .data_out1(data_out1),
        .valid_out0(valid_out0), .valid_out1(valid_out1), .empty0(empty0), .empty1(empty1),
        .full0(full0), .full1(full1), .count0(count0), .count1(count1),
        .err_overflow0(err_overflow0), .err_overflow1(err_overflow1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Lane model: a pop frees a slot before the same-cycle push is considered.
    task automatic model_edge(input bit rst_n, input bit v, input logic [7:0] d,
                              input bit p0, input bit p1);
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            phase = 0;
            exp_dout = '{8'h00, 8'h00};
            exp_vout = '{0, 0};
            exp_err  = '{0, 0};
            return;
        end
        exp_vout[0] = p0 && (exp_q0.size() > 0);
        if (exp_vout[0]) exp_dout[0] = exp_q0.pop_front();
        exp_vout[1] = p1 && (exp_q1.size() > 0);
        if (exp_vout[1]) exp_dout[1] = exp_q1.pop_front();
        if (v && phase == 0) begin
            if (exp_q0.size() < DEPTH) exp_q0.push_back(d);
            else exp_err[0] = 1;
        end
        if (v && phase == 1) begin
            if (exp_q1.size() < DEPTH) exp_q1.push_back(d);
            else exp_err[1] = 1;
        end
        phase = ~phase;
    endtask

    task automatic compare_all();
        check("data_out0", data_out0, exp_dout[0]);
        check("data_out1", data_out1, exp_dout[1]);
        check("valid_out0", valid_out0, exp_vout[0]);
        check("valid_out1", valid_out1, exp_vout[1]);
        check("count0", count0, exp_q0.size());
        check("count1", count1, exp_q1.size());
        check("empty0", empty0, exp_q0.size() == 0);
        check("empty1", empty1, exp_q1.size() == 0);
        check("full0", full0, exp_q0.size() == DEPTH);
        check("full1", full1, exp_q1.size() == DEPTH);
        check("err_overflow0", err_overflow0, exp_err[0]);
        check("err_overflow1", err_overflow1, exp_err[1]);
    endtask

    task automatic step(input bit rst_n, input bit v, input logic [7:0] d,
                        input bit p0, input bit p1);
        @(negedge clk);
        reset_L = rst_n; valid_in = v; data_in = d; pop0 = p0; pop1 = p1;
        @(posedge clk);
        model_edge(rst_n, v, d, p0, p1);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step(0, 0, 8'h00, 0, 0);
    endtask

    initial begin
        reset_L = 0; valid_in = 0; data_in = 0; pop0 = 0; pop1 = 0;

        // T1: reset with random inputs
        for (int i = 0; i < 2; i++)
            step(0, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        check("t1_empty0", empty0, 1);
        check("t1_count1", count1, 0);

        // T2: contiguous striping then drain both lanes
        for (int i = 0; i < 8; i++) step(1, 1, 8'hA0 + 8'(i), 0, 0);
        check("t2_count0", count0, 4);
        check("t2_full1", full1, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 8'h00, 1, 1);
            check("t2_lane0", data_out0, 8'hA0 + 8'(2 * i));
            check("t2_lane1", data_out1, 8'hA1 + 8'(2 * i));
        end
        step(1, 0, 8'h00, 0, 0);

        // T3: valid only on odd phases, then pop0 on empty lane
        do_reset();
        step(1, 0, 8'h00, 0, 0); step(1, 1, 8'h11, 0, 0);
        step(1, 0, 8'h00, 0, 0); step(1, 1, 8'h22, 0, 0);
        step(1, 0, 8'h00, 0, 0); step(1, 1, 8'h33, 0, 0);
        check("t3_count1", count1, 3);
        check("t3_empty0", empty0, 1);
        step(1, 0, 8'h00, 1, 0);
        check("t3_pop_empty", valid_out0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 0, 1);

        // T4: overflow lane 0
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            step(1, 1, 8'(i), 0, 0);
            step(1, 0, 8'h00, 0, 0);
        end
        check("t4_err0", err_overflow0, 1);
        check("t4_err1", err_overflow1, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1, 0, 8'h00, 1, 0);
            check("t4_pop", data_out0, 8'(i));
        end

        // T5: push and pop together on a full lane
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 8'hB0 + 8'(i), 0, 0);
            step(1, 0, 8'h00, 0, 0);
        end
        step(1, 1, 8'hB4, 1, 0);
        check("t5_dout", data_out0, 8'hB0);
        check("t5_count", count0, 4);
        check("t5_err", err_overflow0, 0);
        for (int i = 1; i <= 4; i++) step(1, 0, 8'h00, 1, 0);
        check("t5_last", data_out0, 8'hB4);

        // T6: mid-operation reset with sticky error set beforehand
        do_reset();
        for (int i = 0; i < 12; i++) step(1, 1, 8'hC0 + 8'(i), 0, 0);
        do_reset();
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 1, 8'hD0 + 8'(i), 0, 0);
        check("t6_count0", count0, 2);
        check("t6_count1", count1, 3);
        do_reset();
        check("t6_rst_count0", count0, 0);
        check("t6_rst_err0", err_overflow0, 0);
        step(1, 1, 8'hE0, 0, 0);
        check("t6_lane0_first", count0, 1);

        // random traffic
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) != 0), 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
